mult_div_unit: RTL

//  Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_div_step.sv | 33 +++
 rtl/mult_div_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings driven on mult_div_unit.op
//   - FSM state encoding
//   - LO value written when a divide has a zero divisor
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in       partial remainder so far (always < divisor)
//   divisor      unsigned divisor magnitude
//   dividend_bit next dividend bit shifted into the remainder
//   rem_out      remainder after the trial subtract (restored if negative)
//   q_bit        quotient bit produced by this step
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] sel;
    logic           unused_sel_msb;

    always_comb begin
        trial = {rem_in, dividend_bit};
        diff  = trial - {1'b0, divisor};
        q_bit = (trial >= {1'b0, divisor});
        sel   = q_bit ? diff : trial;
        // rem_in < divisor, so the selected value always fits in WIDTH bits.
        rem_out        = sel[WIDTH-1:0];
        unused_sel_msb = sel[WIDTH];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, op           launch MULT/MULTU/DIV/DIVU; accepted only in IDLE
//   operand_a/operand_b rs / rt values
//   mthi, mtlo          write operand_a into HI / LO while IDLE
//   busy                operation in flight (CALC or FIX)
//   done                one-cycle pulse when HI/LO receive a new result
//   div_by_zero         sticky flag for the last divide; cleared by next start
//   hi, lo              HI / LO registers
// Signedness is resolved at accept (magnitudes + sign bits) and at FIX
// (conditional negate); the iterations themselves are purely unsigned.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(WIDTH-1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;     // product / quotient sign
    logic               rem_neg_q, rem_neg_d;   // remainder sign (dividend sign)
    logic               dz_q, dz_d;             // current divide has zero divisor
    logic [WIDTH-1:0]   mcand_q, mcand_d;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;           // {upper, lower} working register
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_by_zero_q, div_by_zero_d;

    // Signed-operand decode and magnitudes, used only at accept.
    logic               op_signed, op_div, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;

    // Iteration datapaths.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;

    // FIX-stage results.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (acc_q[2*WIDTH-1:WIDTH]),
        .divisor      (mcand_q),
        .dividend_bit (acc_q[WIDTH-1]),
        .rem_out      (div_rem),
        .q_bit        (div_qbit)
    );

    always_comb begin
        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
        sa        = op_signed && operand_a[WIDTH-1];
        sb        = op_signed && operand_b[WIDTH-1];
        abs_a     = sa ? (~operand_a + ONE_W) : operand_a;
        abs_b     = sb ? (~operand_b + ONE_W) : operand_b;

        // Shift-add: add multiplicand to upper half when the LSB of the
        // multiplier (lower half) is set, then shift the whole thing right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

        prod_fix = neg_lo_q  ? (~acc_q + ONE_2W) : acc_q;
        quo_fix  = neg_lo_q  ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_div_d      = is_div_q;
        neg_lo_d      = neg_lo_q;
        rem_neg_d     = rem_neg_q;
        dz_d          = dz_q;
        mcand_d       = mcand_q;
        acc_d         = acc_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_CALC;
                    busy_d        = 1'b1;
                    cnt_d         = '0;
                    is_div_d      = op_div;
                    neg_lo_d      = sa ^ sb;
                    rem_neg_d     = sa;
                    dz_d          = op_div && (operand_b == '0);
                    div_by_zero_d = 1'b0;
                    mcand_d       = op_div ? abs_b : abs_a;
                    acc_d         = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                    // Zero divisor: preload the final HI:LO so FIX just copies it.
                    if (op_div && (operand_b == '0)) begin
                        acc_d = {operand_a, WIDTH'(DIV0_LO)};
                    end
                end else begin
                    if (mthi) hi_d = operand_a;
                    if (mtlo) lo_d = operand_a;
                end
            end
            S_CALC: begin
                if (dz_q) begin
                    state_d = S_FIX;
                end else begin
                    if (is_div_q) begin
                        acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dz_q) begin
                    hi_d          = acc_q[2*WIDTH-1:WIDTH];
                    lo_d          = acc_q[WIDTH-1:0];
                    div_by_zero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            is_div_q      <= 1'b0;
            neg_lo_q      <= 1'b0;
            rem_neg_q     <= 1'b0;
            dz_q          <= 1'b0;
            mcand_q       <= '0;
            acc_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_div_q      <= is_div_d;
            neg_lo_q      <= neg_lo_d;
            rem_neg_q     <= rem_neg_d;
            dz_q          <= dz_d;
            mcand_q       <= mcand_d;
            acc_q         <= acc_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
